// File: rtl/call_scheduler.sv
// Purpose : elevator call scheduler; picks the next destination floor from
//           latched cabin/hall requests using a collective (sweep) policy.
// Latency : SELECT decides in 1 cycle; request to target_valid is 2 cycles.
// Backpr. : target/dir held stable in ISSUE until target_ready is sampled.
//
// Ports
//   clk, reset (async, active-low)
//   req_in/req_up/req_dn   latched cabin, hall-up, hall-down requests
//   cur_floor, arrived     car position and one-cycle stop pulse
//   target, target_valid,  destination handshake towards the motion unit
//   target_ready, dir      travel direction (1 = up)
//   door_req, door_done    door cycle request pulse / completion pulse
//   clr_in/clr_up/clr_dn   one-hot request-clear pulses on door opening
//   busy                   high whenever the FSM is not IDLE
//
// Optional build macro: SCHED_PARK_EN -- return an idle car to floor 0 after
// PARK_CYCLES idle cycles (no door cycle, no request clears on that trip).

module call_scheduler #(
   parameter int FLOORS      = 8,
   parameter int PARK_CYCLES = 1000,
   localparam int FW         = $clog2(FLOORS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] req_in,
   input  logic [FLOORS-1:0] req_up,
   input  logic [FLOORS-1:0] req_dn,
   input  logic [FW-1:0]     cur_floor,
   input  logic              arrived,
   output logic [FW-1:0]     target,
   output logic              target_valid,
   input  logic              target_ready,
   output logic              dir,
   output logic              door_req,
   input  logic              door_done,
   output logic [FLOORS-1:0] clr_in,
   output logic [FLOORS-1:0] clr_up,
   output logic [FLOORS-1:0] clr_dn,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_ISSUE  = 3'd2,
      S_MOVING = 3'd3,
      S_DOOR   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              dir_q, dir_d;
   logic [FW-1:0]     target_q, target_d;
   logic              empty_q, empty_d;
   logic              door_req_q, door_req_d;
   logic [FLOORS-1:0] clr_in_q, clr_in_d;
   logic [FLOORS-1:0] clr_up_q, clr_up_d;
   logic [FLOORS-1:0] clr_dn_q, clr_dn_d;

`ifdef SCHED_PARK_EN
   localparam int PCW = $clog2(PARK_CYCLES + 1);
   logic           park_q, park_d;
   logic [PCW-1:0] park_cnt_q, park_cnt_d;
`endif

   logic              req_pend;
   logic              pri_found, sec_found;
   logic [FW-1:0]     pri_f, sec_f;
   logic              win_vld;
   logic [FW-1:0]     win_f;
   logic              win_dir;
   logic              enter_door;
   logic [FLOORS-1:0] floor_oh;

   assign req_pend = |(req_in | req_up | req_dn);
   assign floor_oh = FLOORS'(1) << cur_floor;

   // Candidate search. The primary set is "on the way" in the current
   // direction; the secondary set is the farthest opposite-direction hall call,
   // which turns the car around at the end of its sweep. Loop order is chosen
   // so the last hit is the winner (lowest when scanning down, highest up).
   always_comb begin
      pri_found = 1'b0;
      pri_f     = '0;
      sec_found = 1'b0;
      sec_f     = '0;
      if (dir_q) begin
         for (int f = FLOORS - 1; f >= 0; f--) begin
            if ((FW'(f) >= cur_floor) && (req_in[f] || req_up[f])) begin
               pri_found = 1'b1;
               pri_f     = FW'(f);
            end
         end
         for (int f = 0; f < FLOORS; f++) begin
            if ((FW'(f) > cur_floor) && req_dn[f]) begin
               sec_found = 1'b1;
               sec_f     = FW'(f);
            end
         end
      end else begin
         for (int f = 0; f < FLOORS; f++) begin
            if ((FW'(f) <= cur_floor) && (req_in[f] || req_dn[f])) begin
               pri_found = 1'b1;
               pri_f     = FW'(f);
            end
         end
         for (int f = FLOORS - 1; f >= 0; f--) begin
            if ((FW'(f) < cur_floor) && req_up[f]) begin
               sec_found = 1'b1;
               sec_f     = FW'(f);
            end
         end
      end
   end

   assign win_vld = pri_found || sec_found;
   assign win_f   = pri_found ? pri_f : sec_f;
   assign win_dir = pri_found ? dir_q : ~dir_q;

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      target_d   = target_q;
      empty_d    = empty_q;
      enter_door = 1'b0;
      door_req_d = 1'b0;
      clr_in_d   = '0;
      clr_up_d   = '0;
      clr_dn_d   = '0;
`ifdef SCHED_PARK_EN
      park_d     = park_q;
      park_cnt_d = '0;
`endif

      case (state_q)
         S_IDLE: begin
            empty_d = 1'b0;
            if (req_pend) begin
               state_d = S_SELECT;
`ifdef SCHED_PARK_EN
            end else if (cur_floor != '0) begin
               if (park_cnt_q == PCW'(PARK_CYCLES - 1)) begin
                  target_d = '0;
                  dir_d    = 1'b0;
                  park_d   = 1'b1;
                  state_d  = S_ISSUE;
               end else begin
                  park_cnt_d = park_cnt_q + 1'b1;
               end
`endif
            end
         end

         S_SELECT: begin
            if (win_vld) begin
               empty_d = 1'b0;
               dir_d   = win_dir;
               if (win_f == cur_floor) begin
                  enter_door = 1'b1;
               end else begin
                  target_d = win_f;
                  state_d  = S_ISSUE;
               end
            end else if (empty_q) begin
               // Nothing in either direction: give up without a second flip.
               empty_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               empty_d = 1'b1;
               dir_d   = ~dir_q;
            end
         end

         S_ISSUE: begin
            if (target_ready) begin
               state_d = S_MOVING;
            end
         end

         S_MOVING: begin
            if (arrived && (cur_floor == target_q)) begin
`ifdef SCHED_PARK_EN
               if (park_q) begin
                  park_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  enter_door = 1'b1;
               end
`else
               enter_door = 1'b1;
`endif
            end
         end

         S_DOOR: begin
            if (door_done) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Door opening clears the cabin call plus the hall call matching the
      // direction the car will leave in.
      if (enter_door) begin
         state_d    = S_DOOR;
         door_req_d = 1'b1;
         clr_in_d   = floor_oh;
         if (dir_d) begin
            clr_up_d = floor_oh;
         end else begin
            clr_dn_d = floor_oh;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         dir_q      <= 1'b1;
         target_q   <= '0;
         empty_q    <= 1'b0;
         door_req_q <= 1'b0;
         clr_in_q   <= '0;
         clr_up_q   <= '0;
         clr_dn_q   <= '0;
`ifdef SCHED_PARK_EN
         park_q     <= 1'b0;
         park_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         target_q   <= target_d;
         empty_q    <= empty_d;
         door_req_q <= door_req_d;
         clr_in_q   <= clr_in_d;
         clr_up_q   <= clr_up_d;
         clr_dn_q   <= clr_dn_d;
`ifdef SCHED_PARK_EN
         park_q     <= park_d;
         park_cnt_q <= park_cnt_d;
`endif
      end
   end

   assign target       = target_q;
   assign target_valid = (state_q == S_ISSUE);
   assign dir          = dir_q;
   assign door_req     = door_req_q;
   assign clr_in       = clr_in_q;
   assign clr_up       = clr_up_q;
   assign clr_dn       = clr_dn_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_call_scheduler.sv
// Purpose : directed, table-driven bench for call_scheduler (FLOORS = 8).
// Latency : each vector is applied for one clock, outputs sampled 1 ns later.
// Backpr. : target_ready stall and mid-trip reset covered by hand sequences.

module tb_call_scheduler;

   logic       clk;
   logic       reset;
   logic [7:0] req_in, req_up, req_dn;
   logic [2:0] cur_floor;
   logic       arrived;
   logic [2:0] target;
   logic       target_valid;
   logic       target_ready;
   logic       dir;
   logic       door_req;
   logic       door_done;
   logic [7:0] clr_in, clr_up, clr_dn;
   logic       busy;

   int checks = 0;
   int errors = 0;

   call_scheduler #(
      .FLOORS      (8),
      .PARK_CYCLES (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_in       (req_in),
      .req_up       (req_up),
      .req_dn       (req_dn),
      .cur_floor    (cur_floor),
      .arrived      (arrived),
      .target       (target),
      .target_valid (target_valid),
      .target_ready (target_ready),
      .dir          (dir),
      .door_req     (door_req),
      .door_done    (door_done),
      .clr_in       (clr_in),
      .clr_up       (clr_up),
      .clr_dn       (clr_dn),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rin, rup, rdn;
      logic [2:0] cur;
      logic       arr, rdy, done;
      logic       e_tv;
      logic [2:0] e_tgt;
      logic       e_dir, e_door, e_busy;
      logic [7:0] e_cin, e_cup, e_cdn;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [7:0] rin, input logic [7:0] rup,
                               input logic [7:0] rdn, input logic [2:0] cur,
                               input logic arr, input logic rdy, input logic done,
                               input logic e_tv, input logic [2:0] e_tgt,
                               input logic e_dir, input logic e_door,
                               input logic e_busy, input logic [7:0] e_cin,
                               input logic [7:0] e_cup, input logic [7:0] e_cdn);
      vec_t v;
      v.rin = rin; v.rup = rup; v.rdn = rdn; v.cur = cur;
      v.arr = arr; v.rdy = rdy; v.done = done;
      v.e_tv = e_tv; v.e_tgt = e_tgt; v.e_dir = e_dir; v.e_door = e_door;
      v.e_busy = e_busy; v.e_cin = e_cin; v.e_cup = e_cup; v.e_cdn = e_cdn;
      return v;
   endfunction

   function automatic logic [30:0] pack_out(input logic tv, input logic [2:0] tg,
                                            input logic d, input logic dr,
                                            input logic b, input logic [7:0] ci,
                                            input logic [7:0] cu, input logic [7:0] cd);
      return {tv, tg, d, dr, b, ci, cu, cd};
   endfunction

   function automatic logic [30:0] dut_out();
      return pack_out(target_valid, target, dir, door_req, busy, clr_in, clr_up, clr_dn);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Output word layout: {tv, target[2:0], dir, door_req, busy, clr_in, clr_up, clr_dn}
   task automatic chk_out(input string name, input logic [30:0] exp);
      chk(name, {1'b0, dut_out()}, {1'b0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_in = '0; req_up = '0; req_dn = '0;
      arrived = 1'b0; target_ready = 1'b0; door_done = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      cur_floor = 3'd0;
      idle_inputs();

      // Stepping-stone scenarios: empty SELECT turnaround, double-empty
      // SELECT, plain cabin call, sweep ordering, top turnaround.
      //            rin   rup   rdn  cur a r d   tv tg dir dr b  cin   cup   cdn
      vecs.push_back(mk(8'h00,8'h00,8'h10,3'd4,0,0,0, 0,3'd0,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h10,3'd4,0,0,0, 0,3'd0,0,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h10,3'd4,0,0,0, 0,3'd0,0,1,1, 8'h10,8'h00,8'h10));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd4,0,0,1, 0,3'd0,0,0,0, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h01,8'h00,8'h00,3'd0,0,0,0, 0,3'd0,0,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd0,0,0,0, 0,3'd0,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd0,0,0,0, 0,3'd0,1,0,0, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd0,0,1,1, 0,3'd0,1,0,0, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h20,8'h00,8'h00,3'd0,0,0,0, 0,3'd0,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h20,8'h00,8'h00,3'd0,0,0,0, 1,3'd5,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h20,8'h00,8'h00,3'd0,0,1,0, 0,3'd5,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h20,8'h00,8'h00,3'd3,1,0,0, 0,3'd5,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h20,8'h00,8'h00,3'd5,1,0,0, 0,3'd5,1,1,1, 8'h20,8'h20,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd5,0,0,0, 0,3'd5,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd5,0,0,1, 0,3'd5,1,0,0, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h10,8'h40,8'h00,3'd3,0,0,0, 0,3'd5,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h10,8'h40,8'h00,3'd3,0,0,0, 1,3'd4,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h10,8'h40,8'h00,3'd3,0,1,0, 0,3'd4,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h10,8'h40,8'h00,3'd4,1,0,0, 0,3'd4,1,1,1, 8'h10,8'h10,8'h00));
      vecs.push_back(mk(8'h00,8'h40,8'h00,3'd4,0,0,1, 0,3'd4,1,0,0, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h40,8'h00,3'd4,0,0,0, 0,3'd4,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h40,8'h00,3'd4,0,0,0, 1,3'd6,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h40,8'h00,3'd4,0,1,0, 0,3'd6,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h40,8'h00,3'd6,1,0,0, 0,3'd6,1,1,1, 8'h40,8'h40,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd6,0,0,1, 0,3'd6,1,0,0, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h80,3'd2,0,0,0, 0,3'd6,1,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h80,3'd2,0,0,0, 1,3'd7,0,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h80,3'd2,0,1,0, 0,3'd7,0,0,1, 8'h00,8'h00,8'h00));
      vecs.push_back(mk(8'h00,8'h00,8'h80,3'd7,1,0,0, 0,3'd7,0,1,1, 8'h80,8'h00,8'h80));
      vecs.push_back(mk(8'h00,8'h00,8'h00,3'd7,0,0,1, 0,3'd7,0,0,0, 8'h00,8'h00,8'h00));

      // Reset state
      #12;
      chk_out("reset_state", pack_out(0, 3'd0, 1, 0, 0, 8'h00, 8'h00, 8'h00));
      @(posedge clk);
      #1;
      reset = 1'b1;

      foreach (vecs[i]) begin
         req_in       = vecs[i].rin;
         req_up       = vecs[i].rup;
         req_dn       = vecs[i].rdn;
         cur_floor    = vecs[i].cur;
         arrived      = vecs[i].arr;
         target_ready = vecs[i].rdy;
         door_done    = vecs[i].done;
         step();
         chk_out($sformatf("vec%0d", i),
                 pack_out(vecs[i].e_tv, vecs[i].e_tgt, vecs[i].e_dir, vecs[i].e_door,
                          vecs[i].e_busy, vecs[i].e_cin, vecs[i].e_cup, vecs[i].e_cdn));
      end

      // Stalled handshake: car at 7 heading down, cabin call at 2, request
      // withdrawn once issued, ready held low for 10 cycles.
      idle_inputs();
      cur_floor = 3'd7;
      req_in    = 8'h04;
      step();
      chk("stall_select_busy", {31'd0, busy}, 32'd1);
      step();
      chk_out("stall_issue", pack_out(1, 3'd2, 0, 0, 1, 8'h00, 8'h00, 8'h00));
      req_in = 8'h00;
      for (int c = 0; c < 10; c++) begin
         step();
         chk_out($sformatf("stall_hold%0d", c), pack_out(1, 3'd2, 0, 0, 1, 8'h00, 8'h00, 8'h00));
      end
      target_ready = 1'b1;
      step();
      target_ready = 1'b0;
      chk_out("stall_moving", pack_out(0, 3'd2, 0, 0, 1, 8'h00, 8'h00, 8'h00));
      cur_floor = 3'd5;
      arrived   = 1'b1;
      step();
      arrived = 1'b0;
      chk_out("wrong_floor_arrival", pack_out(0, 3'd2, 0, 0, 1, 8'h00, 8'h00, 8'h00));

      // Reset mid-MOVING: immediate clear, and no door/clear pulse on an
      // arrival at the old target while held in reset.
      reset = 1'b0;
      #1;
      chk_out("reset_mid_moving", pack_out(0, 3'd0, 1, 0, 0, 8'h00, 8'h00, 8'h00));
      cur_floor = 3'd2;
      arrived   = 1'b1;
      step();
      chk_out("reset_held_arrival", pack_out(0, 3'd0, 1, 0, 0, 8'h00, 8'h00, 8'h00));
      arrived = 1'b0;
      reset   = 1'b1;
      step();
      chk_out("after_reset_idle", pack_out(0, 3'd0, 1, 0, 0, 8'h00, 8'h00, 8'h00));

`ifdef SCHED_PARK_EN
      // Parking: idle at floor 5 with no calls for 16 cycles.
      reset     = 1'b0;
      cur_floor = 3'd5;
      #2;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (15) step();
      chk_out("park_not_yet", pack_out(0, 3'd0, 1, 0, 0, 8'h00, 8'h00, 8'h00));
      step();
      chk_out("park_issue", pack_out(1, 3'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00));
      target_ready = 1'b1;
      step();
      target_ready = 1'b0;
      cur_floor = 3'd0;
      arrived   = 1'b1;
      step();
      arrived = 1'b0;
      chk_out("park_arrival", pack_out(0, 3'd0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
      step();
      chk_out("park_no_late_door", pack_out(0, 3'd0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
